// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: opcodes, ALU select codes,
// FSM states and instruction classes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_LD,
        CLS_ST,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_INC  = 5'b11111;

    // Immediate forms reuse the register-register ALU operation
    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ADDI: return ALU_ADD;
            OP_ANDI: return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Maps a 5-bit opcode to its instruction class; undefined codes map to ILLEGAL.
module opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:       op_class = CLS_IMM;
            OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
            OP_NEG, OP_NOT:                 op_class = CLS_UNARY;
            OP_LD:                          op_class = CLS_LD;
            OP_ST:                          op_class = CLS_ST;
            OP_NOP:                         op_class = CLS_NOP;
            OP_HALT:                        op_class = CLS_HALT;
            default:                        op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore control unit: fetch T0-T2, class-specific execute T3-T7, HALT until clr.
// Control outputs decode from the state register and the latched opcode.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_done,
    input  logic        stop,
    output logic        pc_out,
    output logic        pc_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlow_out,
    output logic        zhi_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic        c_out,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic        read,
    output logic        write,
    output logic [4:0]  alu_select,
    output logic        run,
    output logic        illegal
);

    state_t     state;
    logic [4:0] opcode;
    logic [4:0] dec_op;
    op_class_t  op_class;
    state_t     end_state;
    logic       unused_ir;

    assign unused_ir = ^ir[26:0];

    // In T2 the instruction is still on ir; afterwards only the latched copy counts
    assign dec_op    = (state == ST_T2) ? ir[31:27] : opcode;
    assign end_state = stop ? ST_HALT : ST_T0;

    opcode_decode u_decode (
        .opcode   (dec_op),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= ST_RST;
            opcode  <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= (state == ST_T2) && (op_class == CLS_ILLEGAL);
            if (state == ST_T2)
                opcode <= ir[31:27];
            case (state)
                ST_RST: state <= ST_T0;
                ST_T0:  state <= ST_T1;
                ST_T1:  if (mem_done) state <= ST_T2;
                ST_T2: begin
                    case (op_class)
                        CLS_NOP, CLS_ILLEGAL: state <= end_state;
                        CLS_HALT:             state <= ST_HALT;
                        default:              state <= ST_T3;
                    endcase
                end
                ST_T3:  state <= ST_T4;
                ST_T4:  state <= (op_class == CLS_UNARY) ? end_state : ST_T5;
                ST_T5: begin
                    if (op_class == CLS_RTYPE || op_class == CLS_IMM)
                        state <= end_state;
                    else
                        state <= ST_T6;
                end
                ST_T6: begin
                    if (op_class == CLS_MULDIV)
                        state <= end_state;
                    else if (op_class == CLS_ST || mem_done)
                        state <= ST_T7;
                end
                ST_T7: begin
                    if (op_class == CLS_LD || mem_done)
                        state <= end_state;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    always_comb begin
        pc_out = 1'b0; pc_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
        mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
        zlow_out = 1'b0; zhi_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
        c_out = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
        r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0; read = 1'b0; write = 1'b0;
        alu_select = ALU_NONE;
        run = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: begin pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; alu_select = ALU_INC; end
            ST_T1: begin zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
            ST_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            ST_T3: begin
                case (op_class)
                    CLS_RTYPE, CLS_IMM: begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                    CLS_MULDIV:         begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                    CLS_UNARY: begin
                        grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_select = opcode;
                    end
                    CLS_LD, CLS_ST:     begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_RTYPE: begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_select = opcode; end
                    CLS_IMM:   begin c_out = 1'b1; z_in = 1'b1; alu_select = imm_alu(opcode); end
                    CLS_MULDIV: begin grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_select = opcode; end
                    CLS_UNARY: begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CLS_LD, CLS_ST: begin c_out = 1'b1; z_in = 1'b1; alu_select = ALU_ADD; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CLS_RTYPE, CLS_IMM: begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CLS_MULDIV:         begin zlow_out = 1'b1; lo_in = 1'b1; end
                    CLS_LD, CLS_ST:     begin zlow_out = 1'b1; mar_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (op_class)
                    CLS_MULDIV: begin zhi_out = 1'b1; hi_in = 1'b1; end
                    CLS_LD:     begin read = 1'b1; mdr_in = 1'b1; end
                    CLS_ST:     begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (op_class)
                    CLS_LD:  begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    CLS_ST:  write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-cycle program of inputs and expected
// control words is generated from instruction-level micro-step tables.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr, mem_done, stop;
    logic [31:0] ir;
    logic pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhi_out;
    logic hi_in, lo_in, c_out, gra, grb, grc, r_in, r_out, ba_out, read, write, run, illegal;
    logic [4:0] alu_select;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_done(mem_done), .stop(stop),
        .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zlow_out(zlow_out), .zhi_out(zhi_out), .hi_in(hi_in), .lo_in(lo_in),
        .c_out(c_out), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
        .r_out(r_out), .ba_out(ba_out), .read(read), .write(write),
        .alu_select(alu_select), .run(run), .illegal(illegal)
    );

    localparam logic [27:0] PC_OUT = 28'd1 << 0,  PC_IN = 28'd1 << 1,  MAR_IN = 28'd1 << 2;
    localparam logic [27:0] MDR_IN = 28'd1 << 3,  MDR_OUT = 28'd1 << 4, IR_IN = 28'd1 << 5;
    localparam logic [27:0] Y_IN = 28'd1 << 6,    Z_IN = 28'd1 << 7,   ZLOW_OUT = 28'd1 << 8;
    localparam logic [27:0] ZHI_OUT = 28'd1 << 9, HI_IN = 28'd1 << 10, LO_IN = 28'd1 << 11;
    localparam logic [27:0] C_OUT = 28'd1 << 12,  GRA = 28'd1 << 13,   GRB = 28'd1 << 14;
    localparam logic [27:0] GRC = 28'd1 << 15,    R_IN = 28'd1 << 16,  R_OUT = 28'd1 << 17;
    localparam logic [27:0] BA_OUT = 28'd1 << 18, READ = 28'd1 << 19,  WRITE = 28'd1 << 20;
    localparam logic [27:0] RUN = 28'd1 << 21,    ILL = 28'd1 << 22;

    localparam int K_R = 0, K_IMM = 1, K_MD = 2, K_UN = 3, K_LD = 4, K_ST = 5, K_NOP = 6,
                   K_HALT = 7, K_ILL = 8;

    logic [27:0] act;
    assign act = {alu_select, illegal, run, write, read, ba_out, r_out, r_in, grc, grb, gra,
                  c_out, lo_in, hi_in, zhi_out, zlow_out, z_in, y_in, ir_in, mdr_out, mdr_in,
                  mar_in, pc_in, pc_out};

    typedef struct {
        logic [31:0] irv;
        logic        md;
        logic        st;
        logic        cl;
        logic [27:0] exp;
    } cyc_t;

    cyc_t        prog[$];
    logic [27:0] sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          pend_ill = 0;

    function automatic logic [27:0] alu(input logic [4:0] v);
        return {v, 23'd0};
    endfunction

    function automatic int kind(input logic [4:0] op);
        if (op inside {[5'd3:5'd10]}) return K_R;
        if (op inside {[5'd11:5'd13]}) return K_IMM;
        if (op inside {5'd14, 5'd15}) return K_MD;
        if (op inside {5'd16, 5'd17}) return K_UN;
        if (op == 5'd0) return K_LD;
        if (op == 5'd2) return K_ST;
        if (op == 5'd24) return K_NOP;
        if (op == 5'd25) return K_HALT;
        return K_ILL;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic mid(input bit force_stop);
        return force_stop ? 1'b1 : ($urandom_range(0, 3) == 0);
    endfunction

    task automatic emit(input logic [27:0] e, input logic [31:0] irv, input logic md,
                        input logic st, input logic cl);
        cyc_t c;
        c.exp = pend_ill ? (e | ILL) : e;
        pend_ill = 0;
        c.irv = irv; c.md = md; c.st = st; c.cl = cl;
        prog.push_back(c);
    endtask

    // res: 0 = next instruction fetch, 1 = halted, 2 = reset taken mid-instruction
    task automatic run_instr(input logic [4:0] op, input logic [26:0] lo, input int d1,
                             input int d2, input bit stop_end, input bit stop_mid,
                             input int abort, output int res);
        logic [27:0] body[$];
        bit          wt[$];
        logic [27:0] fetch1;
        logic [27:0] imm_code;
        int          k;
        k = kind(op);
        fetch1 = RUN | ZLOW_OUT | PC_IN | READ | MDR_IN;
        emit(RUN | PC_OUT | MAR_IN | Z_IN | alu(5'b11111), $urandom, rb(), mid(stop_mid), 0);
        for (int i = 0; i < d1; i++) emit(fetch1, $urandom, 0, mid(stop_mid), 0);
        emit(fetch1, $urandom, 1, mid(stop_mid), 0);
        if (k == K_NOP || k == K_ILL) begin
            emit(RUN | MDR_OUT | IR_IN, {op, lo}, rb(), stop_end, 0);
            if (k == K_ILL) pend_ill = 1;
            res = stop_end ? 1 : 0;
            return;
        end
        emit(RUN | MDR_OUT | IR_IN, {op, lo}, rb(), mid(stop_mid), 0);
        if (k == K_HALT) begin
            res = 1;
            return;
        end
        imm_code = (op == 5'd11) ? alu(5'b00011) : (op == 5'd12) ? alu(5'b00101) : alu(5'b00110);
        case (k)
            K_R: begin
                body = '{GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN | alu(op), ZLOW_OUT | GRA | R_IN};
                wt = '{0, 0, 0};
            end
            K_IMM: begin
                body = '{GRB | R_OUT | Y_IN, C_OUT | Z_IN | imm_code, ZLOW_OUT | GRA | R_IN};
                wt = '{0, 0, 0};
            end
            K_MD: begin
                body = '{GRA | R_OUT | Y_IN, GRB | R_OUT | Z_IN | alu(op), ZLOW_OUT | LO_IN,
                         ZHI_OUT | HI_IN};
                wt = '{0, 0, 0, 0};
            end
            K_UN: begin
                body = '{GRB | R_OUT | Z_IN | alu(op), ZLOW_OUT | GRA | R_IN};
                wt = '{0, 0};
            end
            K_LD: begin
                body = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00011), ZLOW_OUT | MAR_IN,
                         READ | MDR_IN, MDR_OUT | GRA | R_IN};
                wt = '{0, 0, 0, 1, 0};
            end
            default: begin
                body = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00011), ZLOW_OUT | MAR_IN,
                         GRA | R_OUT | MDR_IN, WRITE};
                wt = '{0, 0, 0, 0, 1};
            end
        endcase
        for (int i = 0; i < body.size(); i++) begin
            logic stv;
            stv = (i == body.size() - 1) ? stop_end : mid(stop_mid);
            if (wt[i]) begin
                if (abort >= 0) begin
                    for (int j = 0; j < abort; j++) emit(RUN | body[i], $urandom, 0, mid(stop_mid), 0);
                    emit(RUN | body[i], $urandom, 0, mid(stop_mid), 1);
                    res = 2;
                    return;
                end
                for (int j = 0; j < d2; j++) emit(RUN | body[i], $urandom, 0, mid(stop_mid), 0);
                emit(RUN | body[i], $urandom, 1, stv, 0);
            end else begin
                emit(RUN | body[i], $urandom, rb(), stv, 0);
            end
        end
        res = stop_end ? 1 : 0;
    endtask

    task automatic halt_tail(input int n);
        for (int i = 0; i < n; i++) emit(28'd0, $urandom, rb(), rb(), 0);
        emit(28'd0, $urandom, rb(), rb(), 1);
        emit(28'd0, $urandom, rb(), 0, 0);
    endtask

    task automatic follow(input int res);
        if (res == 1) halt_tail($urandom_range(1, 4));
        else if (res == 2) emit(28'd0, $urandom, rb(), 0, 0);
    endtask

    initial begin : monitor
        logic [27:0] e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL ctrl_word vec %0d t=%0t: got %h want %h", vectors, $time, act, e);
                end
            end
        end
    end

    initial begin : stim
        int res;
        clr = 1'b1; ir = '0; mem_done = 1'b0; stop = 1'b0;

        emit(28'd0, 32'd0, 0, 0, 1);
        emit(28'd0, 32'd0, 0, 0, 0);
        run_instr(5'b00011, 27'd0, 0, 0, 0, 0, -1, res); follow(res);
        run_instr(5'b00000, 27'($urandom), 3, 3, 0, 0, -1, res); follow(res);
        run_instr(5'b01110, 27'($urandom), 1, 0, 0, 0, -1, res); follow(res);
        run_instr(5'b00100, 27'($urandom), 0, 0, 1, 1, -1, res);
        halt_tail(10);
        run_instr(5'b10101, 27'($urandom), 2, 0, 0, 0, -1, res); follow(res);
        run_instr(5'b00011, 27'($urandom), 0, 0, 0, 0, -1, res); follow(res);
        run_instr(5'b00010, 27'($urandom), 0, 0, 0, 0, 2, res); follow(res);
        for (int n = 0; n < 150; n++) begin
            logic [4:0] op;
            int ab;
            op = 5'($urandom_range(0, 31));
            ab = (kind(op) == K_ST && $urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            run_instr(op, 27'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 14) == 0, 0, ab, res);
            follow(res);
        end

        repeat (2) @(posedge clk);
        foreach (prog[i]) begin
            #1;
            ir = prog[i].irv; mem_done = prog[i].md; stop = prog[i].st; clr = prog[i].cl;
            sb.push_back(prog[i].exp);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected words left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
